// File: rtl/alu_arbiter.sv
// ----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one multi-cycle ALU between two requesters. A command (op, A, B) is
// accepted from one requester at a time. Ties are broken round-robin. ALU ops
// (1..4) hold alu_start high until alu_done or a timeout. Local ops (0 = no-op,
// 5..7 = invalid) answer directly. Every accepted command returns exactly one
// single-cycle response to its owner.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   reqN_valid/op/A/B            command from requester N (held until ready)
//   reqN_ready                   combinational accept strobe (valid & ready)
//   rspN_valid/result/err        one-cycle response pulse to requester N
//   alu_start/op/A/B             ALU command, stable throughout RUN
//   alu_done/result              ALU completion and result
//   busy                         high whenever a command is in flight
// ----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int unsigned TIMEOUT_CKS = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    // Requester 0
    input  logic        req0_valid,
    input  logic [2:0]  req0_op,
    input  logic [7:0]  req0_A,
    input  logic [7:0]  req0_B,
    output logic        req0_ready,
    output logic        rsp0_valid,
    output logic [15:0] rsp0_result,
    output logic        rsp0_err,
    // Requester 1
    input  logic        req1_valid,
    input  logic [2:0]  req1_op,
    input  logic [7:0]  req1_A,
    input  logic [7:0]  req1_B,
    output logic        req1_ready,
    output logic        rsp1_valid,
    output logic [15:0] rsp1_result,
    output logic        rsp1_err,
    // ALU side
    output logic        alu_start,
    output logic [2:0]  alu_op,
    output logic [7:0]  alu_A,
    output logic [7:0]  alu_B,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    // Status
    output logic        busy
);

    // Counter value seen in the last permitted RUN cycle.
    localparam logic [7:0] CntLast = 8'(TIMEOUT_CKS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StResp
    } state_e;

    state_e      state_q;
    logic        last_grant_q;
    logic        owner_q;
    logic [7:0]  cnt_q;
    logic [2:0]  op_q;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [15:0] result_q;
    logic        err_q;
    logic        start_q;
    logic        rsp0_valid_q;
    logic        rsp1_valid_q;

    // Arbitration and payload selection.
    logic       grant0;
    logic       grant1;
    logic       accept;
    logic       win;
    logic [2:0] sel_op;
    logic [7:0] sel_a;
    logic [7:0] sel_b;
    logic       sel_is_alu;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        // Gated by reset_n so no ready leaks out while reset is held.
        if (state_q == StIdle && reset_n) begin
            if (req0_valid && req1_valid) begin
                // Tie goes to whoever did not win last time.
                grant0 = last_grant_q;
                grant1 = ~last_grant_q;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
        accept     = grant0 | grant1;
        win        = grant1;
        sel_op     = win ? req1_op : req0_op;
        sel_a      = win ? req1_A  : req0_A;
        sel_b      = win ? req1_B  : req0_B;
        sel_is_alu = (sel_op >= 3'd1) && (sel_op <= 3'd4);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            cnt_q        <= 8'd0;
            op_q         <= 3'd0;
            a_q          <= 8'd0;
            b_q          <= 8'd0;
            result_q     <= 16'd0;
            err_q        <= 1'b0;
            start_q      <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    rsp0_valid_q <= 1'b0;
                    rsp1_valid_q <= 1'b0;
                    if (accept) begin
                        owner_q      <= win;
                        last_grant_q <= win;
                        op_q         <= sel_op;
                        a_q          <= sel_a;
                        b_q          <= sel_b;
                        cnt_q        <= 8'd0;
                        if (sel_is_alu) begin
                            state_q <= StRun;
                            start_q <= 1'b1;
                        end else begin
                            // No-op answers cleanly; 5..7 answer with error.
                            state_q      <= StResp;
                            result_q     <= 16'd0;
                            err_q        <= (sel_op != 3'd0);
                            rsp0_valid_q <= ~win;
                            rsp1_valid_q <= win;
                        end
                    end
                end

                StRun: begin
                    cnt_q <= cnt_q + 8'd1;
                    // Done takes priority over a coincident timeout.
                    if (alu_done) begin
                        state_q      <= StResp;
                        start_q      <= 1'b0;
                        result_q     <= alu_result;
                        err_q        <= 1'b0;
                        rsp0_valid_q <= ~owner_q;
                        rsp1_valid_q <= owner_q;
                    end else if (cnt_q == CntLast) begin
                        state_q      <= StResp;
                        start_q      <= 1'b0;
                        result_q     <= 16'd0;
                        err_q        <= 1'b1;
                        rsp0_valid_q <= ~owner_q;
                        rsp1_valid_q <= owner_q;
                    end
                end

                StResp: begin
                    state_q      <= StIdle;
                    rsp0_valid_q <= 1'b0;
                    rsp1_valid_q <= 1'b0;
                end

                default: begin
                    state_q      <= StIdle;
                    start_q      <= 1'b0;
                    rsp0_valid_q <= 1'b0;
                    rsp1_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req0_ready  = grant0;
    assign req1_ready  = grant1;

    // Result and error are shared; only the owner's valid qualifies them.
    assign rsp0_valid  = rsp0_valid_q;
    assign rsp0_result = result_q;
    assign rsp0_err    = err_q;
    assign rsp1_valid  = rsp1_valid_q;
    assign rsp1_result = result_q;
    assign rsp1_err    = err_q;

    assign alu_start   = start_q;
    assign alu_op      = op_q;
    assign alu_A       = a_q;
    assign alu_B       = b_q;

    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_alu_arbiter.sv
// ----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Directed bench for alu_arbiter. Inputs change and outputs are sampled 1 ns
// after the rising edge; the ALU is played by the bench via alu_done/result.
// ----------------------------------------------------------------------------
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0_valid, req1_valid;
    logic [2:0]  req0_op, req1_op;
    logic [7:0]  req0_A, req0_B, req1_A, req1_B;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic [15:0] rsp0_result, rsp1_result;
    logic        rsp0_err, rsp1_err;
    logic        alu_start;
    logic [2:0]  alu_op;
    logic [7:0]  alu_A, alu_B;
    logic        alu_done;
    logic [15:0] alu_result;
    logic        busy;

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.TIMEOUT_CKS(8)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req0_valid  (req0_valid),
        .req0_op     (req0_op),
        .req0_A      (req0_A),
        .req0_B      (req0_B),
        .req0_ready  (req0_ready),
        .rsp0_valid  (rsp0_valid),
        .rsp0_result (rsp0_result),
        .rsp0_err    (rsp0_err),
        .req1_valid  (req1_valid),
        .req1_op     (req1_op),
        .req1_A      (req1_A),
        .req1_B      (req1_B),
        .req1_ready  (req1_ready),
        .rsp1_valid  (rsp1_valid),
        .rsp1_result (rsp1_result),
        .rsp1_err    (rsp1_err),
        .alu_start   (alu_start),
        .alu_op      (alu_op),
        .alu_A       (alu_A),
        .alu_B       (alu_B),
        .alu_done    (alu_done),
        .alu_result  (alu_result),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req0_valid = 1'b0; req0_op = 3'd0; req0_A = 8'd0; req0_B = 8'd0;
        req1_valid = 1'b0; req1_op = 3'd0; req1_A = 8'd0; req1_B = 8'd0;
        alu_done = 1'b0; alu_result = 16'd0;
        #3;
        checks++;
        if ({busy, alu_start, rsp0_valid, rsp1_valid, req0_ready, req1_ready} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {busy, alu_start, rsp0_valid, rsp1_valid, req0_ready, req1_ready});
        end
        checks++;
        if ({rsp0_result, rsp0_err, rsp1_err, alu_op, alu_A, alu_B} !== 38'd0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0",
                     {rsp0_result, rsp0_err, rsp1_err, alu_op, alu_A, alu_B});
        end
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_add();
        req0_valid = 1'b1; req0_op = 3'd1; req0_A = 8'h12; req0_B = 8'h34;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++; $display("FAIL add_ready: got %b want 10", {req0_ready, req1_ready});
        end
        step();
        req0_valid = 1'b0;
        checks++;
        if ({alu_start, busy, alu_op, alu_A, alu_B} !== {1'b1, 1'b1, 3'd1, 8'h12, 8'h34}) begin
            errors++;
            $display("FAIL add_run: got %h want %h", {alu_start, busy, alu_op, alu_A, alu_B},
                     {1'b1, 1'b1, 3'd1, 8'h12, 8'h34});
        end
        alu_done = 1'b1; alu_result = 16'h0046;
        step();
        alu_done = 1'b0;
        checks++;
        if ({rsp0_valid, rsp1_valid, alu_start} !== 3'b100) begin
            errors++;
            $display("FAIL add_rsp_valid: got %b want 100", {rsp0_valid, rsp1_valid, alu_start});
        end
        checks++;
        if ({rsp0_result, rsp0_err} !== {16'h0046, 1'b0}) begin
            errors++;
            $display("FAIL add_rsp_data: got %h/%b want 0046/0", rsp0_result, rsp0_err);
        end
        step();
        checks++;
        if ({rsp0_valid, rsp1_valid, busy} !== 3'b000) begin
            errors++;
            $display("FAIL add_idle: got %b want 000", {rsp0_valid, rsp1_valid, busy});
        end
    endtask

    task automatic test_mul();
        req1_valid = 1'b1; req1_op = 3'd4; req1_A = 8'hFF; req1_B = 8'hFF;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            errors++; $display("FAIL mul_ready: got %b want 01", {req0_ready, req1_ready});
        end
        step();
        req1_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            checks++;
            if ({alu_start, busy, rsp1_valid} !== 3'b110) begin
                errors++;
                $display("FAIL mul_run%0d: got %b want 110", i, {alu_start, busy, rsp1_valid});
            end
            if (i == 3) begin
                alu_done = 1'b1; alu_result = 16'hFE01;
            end
            step();
            alu_done = 1'b0;
        end
        checks++;
        if ({rsp1_valid, rsp0_valid, alu_start, busy} !== 4'b1001) begin
            errors++;
            $display("FAIL mul_rsp_valid: got %b want 1001",
                     {rsp1_valid, rsp0_valid, alu_start, busy});
        end
        checks++;
        if ({rsp1_result, rsp1_err} !== {16'hFE01, 1'b0}) begin
            errors++;
            $display("FAIL mul_rsp_data: got %h/%b want fe01/0", rsp1_result, rsp1_err);
        end
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL mul_busy_end: got %b want 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] op0 [3];
        logic [7:0] a0  [3];
        logic [7:0] b0  [3];
        logic [2:0] op1 [3];
        logic [7:0] a1  [3];
        logic [7:0] b1  [3];
        int i0, i1, g;
        logic [2:0] eop;
        logic [7:0] ea, eb;
        op0[0] = 3'd1; a0[0] = 8'h10; b0[0] = 8'h20;
        op0[1] = 3'd2; a0[1] = 8'h11; b0[1] = 8'h21;
        op0[2] = 3'd3; a0[2] = 8'h12; b0[2] = 8'h22;
        op1[0] = 3'd4; a1[0] = 8'h30; b1[0] = 8'h40;
        op1[1] = 3'd1; a1[1] = 8'h31; b1[1] = 8'h41;
        op1[2] = 3'd2; a1[2] = 8'h32; b1[2] = 8'h42;
        i0 = 0; i1 = 0;
        req0_valid = 1'b1; req0_op = op0[0]; req0_A = a0[0]; req0_B = b0[0];
        req1_valid = 1'b1; req1_op = op1[0]; req1_A = a1[0]; req1_B = b1[0];
        for (int n = 0; n < 6; n++) begin
            g = n % 2;
            #1;
            checks++;
            if ({req0_ready, req1_ready} !== ((g == 0) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL b2b_grant%0d: got %b want %b", n, {req0_ready, req1_ready},
                         (g == 0) ? 2'b10 : 2'b01);
            end
            if (g == 0) begin
                eop = op0[i0]; ea = a0[i0]; eb = b0[i0];
            end else begin
                eop = op1[i1]; ea = a1[i1]; eb = b1[i1];
            end
            step();
            if (g == 0) begin
                i0++;
                if (i0 < 3) begin
                    req0_op = op0[i0]; req0_A = a0[i0]; req0_B = b0[i0];
                end else begin
                    req0_valid = 1'b0;
                end
            end else begin
                i1++;
                if (i1 < 3) begin
                    req1_op = op1[i1]; req1_A = a1[i1]; req1_B = b1[i1];
                end else begin
                    req1_valid = 1'b0;
                end
            end
            #1;
            checks++;
            if ({req0_ready, req1_ready, alu_start, alu_op, alu_A, alu_B} !==
                {2'b00, 1'b1, eop, ea, eb}) begin
                errors++;
                $display("FAIL b2b_run%0d: got %h want %h", n,
                         {req0_ready, req1_ready, alu_start, alu_op, alu_A, alu_B},
                         {2'b00, 1'b1, eop, ea, eb});
            end
            alu_done = 1'b1; alu_result = {ea, eb};
            step();
            alu_done = 1'b0;
            checks++;
            if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid} !==
                ((g == 0) ? 4'b0010 : 4'b0001)) begin
                errors++;
                $display("FAIL b2b_rsp%0d: got %b want %b", n,
                         {req0_ready, req1_ready, rsp0_valid, rsp1_valid},
                         (g == 0) ? 4'b0010 : 4'b0001);
            end
            checks++;
            if (((g == 0) ? rsp0_result : rsp1_result) !== {ea, eb}) begin
                errors++;
                $display("FAIL b2b_result%0d: got %h want %h", n,
                         (g == 0) ? rsp0_result : rsp1_result, {ea, eb});
            end
            step();
        end
    endtask

    task automatic test_timeout();
        int width;
        req0_valid = 1'b1; req0_op = 3'd2; req0_A = 8'h01; req0_B = 8'h02;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++; $display("FAIL to_ready: got %b want 1", req0_ready);
        end
        step();
        req0_valid = 1'b0;
        width = 0;
        while (alu_start === 1'b1 && width < 20) begin
            width++;
            step();
        end
        checks++;
        if (width != 8) begin
            errors++; $display("FAIL to_start_width: got %0d want 8", width);
        end
        checks++;
        if ({rsp0_valid, rsp0_result, rsp0_err} !== {1'b1, 16'h0000, 1'b1}) begin
            errors++;
            $display("FAIL to_rsp: got %b/%h/%b want 1/0000/1", rsp0_valid, rsp0_result, rsp0_err);
        end
        step();
        // A normal command right after the timeout.
        req0_valid = 1'b1; req0_op = 3'd3; req0_A = 8'h05; req0_B = 8'h06;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++; $display("FAIL to_next_ready: got %b want 1", req0_ready);
        end
        step();
        req0_valid = 1'b0;
        alu_done = 1'b1; alu_result = 16'h1234;
        step();
        alu_done = 1'b0;
        checks++;
        if ({rsp0_valid, rsp0_result, rsp0_err} !== {1'b1, 16'h1234, 1'b0}) begin
            errors++;
            $display("FAIL to_next_rsp: got %b/%h/%b want 1/1234/0",
                     rsp0_valid, rsp0_result, rsp0_err);
        end
        step();
    endtask

    task automatic test_local_ops();
        req0_valid = 1'b1; req0_op = 3'd0; req0_A = 8'hAA; req0_B = 8'h55;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++; $display("FAIL nop_ready: got %b want 1", req0_ready);
        end
        step();
        req0_valid = 1'b0;
        checks++;
        if ({rsp0_valid, rsp0_result, rsp0_err, alu_start, busy} !==
            {1'b1, 16'h0000, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL nop_rsp: got %h want %h", {rsp0_valid, rsp0_result, rsp0_err,
                     alu_start, busy}, {1'b1, 16'h0000, 1'b0, 1'b0, 1'b1});
        end
        step();
        req0_valid = 1'b1; req0_op = 3'd6; req0_A = 8'h77; req0_B = 8'h88;
        #1;
        checks++;
        if ({req0_ready, busy} !== 2'b10) begin
            errors++; $display("FAIL inv_ready: got %b want 10", {req0_ready, busy});
        end
        step();
        req0_valid = 1'b0;
        checks++;
        if ({rsp0_valid, rsp0_result, rsp0_err, alu_start} !==
            {1'b1, 16'h0000, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL inv_rsp: got %h want %h", {rsp0_valid, rsp0_result, rsp0_err,
                     alu_start}, {1'b1, 16'h0000, 1'b1, 1'b0});
        end
        step();
        checks++;
        if ({rsp0_valid, alu_start} !== 2'b00) begin
            errors++; $display("FAIL inv_after: got %b want 00", {rsp0_valid, alu_start});
        end
    endtask

    task automatic test_reset_midrun();
        // Owned by req0 so last_grant is 0 before the reset.
        req0_valid = 1'b1; req0_op = 3'd4; req0_A = 8'h03; req0_B = 8'h04;
        #1;
        step();
        req0_valid = 1'b0;
        step();
        checks++;
        if ({alu_start, busy} !== 2'b11) begin
            errors++; $display("FAIL rst_run2: got %b want 11", {alu_start, busy});
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({alu_start, busy, rsp0_valid, rsp1_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_async: got %b want 0000", {alu_start, busy, rsp0_valid, rsp1_valid});
        end
        alu_done = 1'b1; alu_result = 16'h000C;
        @(posedge clk);
        @(posedge clk);
        #1;
        alu_done = 1'b0;
        reset_n = 1'b1;
        step();
        checks++;
        if ({rsp0_valid, rsp1_valid, busy, alu_start} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_no_rsp: got %b want 0000", {rsp0_valid, rsp1_valid, busy, alu_start});
        end
        req0_valid = 1'b1; req0_op = 3'd0;
        req1_valid = 1'b1; req1_op = 3'd0;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++; $display("FAIL rst_tie: got %b want 10", {req0_ready, req1_ready});
        end
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checks++;
        if ({rsp0_valid, rsp1_valid} !== 2'b10) begin
            errors++; $display("FAIL rst_tie_rsp: got %b want 10", {rsp0_valid, rsp1_valid});
        end
        step();
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_back_to_back();
        test_timeout();
        test_local_ops();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "simulation time limit exceeded");
    end

endmodule
